if_fetch_stage: RTL and testbench
=================================

Name: if_fetch_stage

Overview:
Instruction fetch stage of the 5-stage RV32I pipeline, directly upstream of the decode/control unit.
- Owns the PC.
- Issues one-outstanding requests to instruction memory over a req/gnt/rvalid handshake.
- Drives the IF/ID pipeline register that feeds the opcode to control decode.
- Honours ID stalls (hazard unit) and EX redirects (branch/JAL/JALR resolution).

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset
NOP_INST, 32'h0000_0013, instruction word presented in IF/ID when invalid (addi x0,x0,0)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous, active-high reset
imem_req  out  1  fetch request valid
imem_addr  out  32  fetch address, word aligned
imem_gnt  in  1  request accepted this cycle (qualified by imem_req)
imem_rvalid  in  1  response data valid, exactly one per granted request, at least 1 cycle after gnt
imem_rdata  in  32  instruction word
id_stall  in  1  ID cannot accept; IF/ID must hold
ex_redirect  in  1  taken branch/jump resolved in EX
ex_target  in  32  redirect target
if_id_valid  out  1  IF/ID holds a live instruction
if_id_pc  out  32  PC of IF/ID instruction
if_id_inst  out  32  instruction word to decode
if_id_pred_taken  out  1  instruction was predicted taken (see Optional Feature)

Behaviour:
- Reset (rst=1 at edge): pc=RESET_PC, state=IDLE, imem_req=0, imem_addr=RESET_PC, if_id_valid=0, if_id_pc=0, if_id_inst=NOP_INST, if_id_pred_taken=0, drop=0, hold buffer invalid. Reset asserted mid-transaction abandons any outstanding response; an imem_rvalid arriving after reset release while in IDLE/REQ is ignored.
- FSM states:
  - IDLE: one cycle after reset; -> REQ.
  - REQ: imem_req=1, imem_addr=pc. On gnt -> RESP.
  - RESP: wait rvalid. On rvalid with !drop and !id_stall: load IF/ID {1,pc,rdata}, pc<=pc+4, -> REQ. On rvalid with id_stall: capture into hold buffer, -> HOLD. On rvalid with drop: discard, clear drop, -> REQ.
  - HOLD: when !id_stall: load IF/ID from hold buffer, pc<=pc+4, -> REQ.
- imem_req is a registered output; asserted only in REQ. Request addr is stable while req=1 and gnt=0.
- Fetch latency: minimum 3 cycles from REQ entry to if_id_valid (REQ+gnt, RESP+rvalid, register).
- IF/ID update: with id_stall=1 the register holds all fields. With id_stall=0 and no new instruction this cycle: if_id_valid<=0 and if_id_inst<=NOP_INST.
- Redirect (ex_redirect=1) has highest priority in every state:
  - pc<={ex_target[31:2],2'b00}.
  - IF/ID flushed (valid=0, inst=NOP_INST) even if id_stall=1.
  - REQ without gnt: new address takes effect next cycle, stay REQ.
  - REQ with gnt: -> RESP with drop=1.
  - RESP without rvalid: drop=1.
  - RESP with rvalid same cycle: response discarded, -> REQ.
  - HOLD: hold buffer discarded, -> REQ.
- PC arithmetic is 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 0.
- Simultaneous id_stall and rvalid in RESP: data goes to hold buffer only; no data is lost or duplicated.

Optional Feature:
- Macro IF_JAL_PRED_EN.
- Defined: when an instruction with opcode 7'b1101111 (JAL) is loaded into IF/ID:
  - next pc = pc + sign-extended J-immediate ({inst[31],inst[19:12],inst[20],inst[30:21],1'b0}) instead of pc+4.
  - if_id_pred_taken=1 (0 for all others). EX uses this to suppress a redundant redirect.
  - ex_redirect still overrides.
- Undefined: next pc is always pc+4 and if_id_pred_taken is tied 0.

Test Plan:
- Reset then gnt immediate, rvalid 1 cycle later, rdata=32'h00500093 -> imem_addr 0,4,8…; if_id_valid=1, if_id_pc=0, if_id_inst=32'h00500093 on the 3rd cycle after reset release.
- id_stall=1 for 4 cycles while rvalid arrives with 32'h00208133 -> IF/ID holds prior instr; after release IF/ID shows 32'h00208133, next imem_addr = pc+4, no duplicate or missing PC.
- ex_redirect=1, ex_target=32'h100 while in RESP (rvalid 2 cycles later) -> stale response dropped, if_id_valid=0, next request addr 32'h100, next valid if_id_pc=32'h100.
- ex_target=32'h0000_0203 -> imem_addr=32'h200; redirect coinciding with id_stall=1 still flushes if_id_valid to 0.
- rst pulsed while RESP outstanding, late rvalid after release -> ignored, first fetch at RESET_PC, if_id_inst=NOP_INST until the valid fetch.
- IF_JAL_PRED_EN: fetch 32'h0100006F at pc 0x40 -> if_id_pred_taken=1, next imem_addr=0x50; without the macro, next imem_addr=0x44 and pred_taken=0.

Source files
------------

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: RV32I instruction fetch. Owns the PC, keeps one imem request in flight, drives IF/ID.
// Optional macro IF_JAL_PRED_EN: predict JAL targets at fetch and flag them in if_id_pred_taken.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        id_stall,
  input  logic        ex_redirect,
  input  logic [31:0] ex_target,
  output logic        if_id_valid,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_inst,
  output logic        if_id_pred_taken,
  output logic [1:0]  dbg_state
);

  // Handshakes: a request transfers on a cycle with imem_req && imem_gnt, and imem_addr stays put
  // until then unless a redirect moves it. Each granted request returns exactly one imem_rvalid
  // beat at least one cycle later. IF/ID transfers to decode on any cycle with if_id_valid && !id_stall.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t      state, state_d;
  logic [31:0] pc, pc_d;
  logic [31:0] hold_inst, hold_inst_d;
  logic        hold_valid, hold_valid_d;
  logic        drop, drop_d;
  logic        load;
  logic [31:0] load_inst;
  logic [31:0] load_next_pc;
  logic        load_is_jal;
  logic        unused_target_lsbs;

  assign unused_target_lsbs = ^ex_target[1:0];
  assign imem_addr          = {pc[31:2], 2'b00};
  assign dbg_state          = state;
  assign load_inst          = (state == S_HOLD) ? hold_inst : imem_rdata;

`ifdef IF_JAL_PRED_EN
  logic [31:0] jal_imm;
  assign load_is_jal  = (load_inst[6:0] == 7'b1101111);
  assign jal_imm      = {{11{load_inst[31]}}, load_inst[31], load_inst[19:12],
                         load_inst[20], load_inst[30:21], 1'b0};
  assign load_next_pc = load_is_jal ? (pc + jal_imm) : (pc + 32'd4);
`else
  assign load_is_jal  = 1'b0;
  assign load_next_pc = pc + 32'd4;
`endif

  always_comb begin
    state_d      = state;
    pc_d         = pc;
    drop_d       = drop;
    hold_valid_d = hold_valid;
    hold_inst_d  = hold_inst;
    load         = 1'b0;

    unique case (state)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (imem_gnt) state_d = S_RESP;
      end
      S_RESP: begin
        if (imem_rvalid) begin
          if (drop) begin
            drop_d  = 1'b0;
            state_d = S_REQ;
          end else if (id_stall) begin
            hold_valid_d = 1'b1;
            hold_inst_d  = imem_rdata;
            state_d      = S_HOLD;
          end else begin
            load    = 1'b1;
            state_d = S_REQ;
          end
        end
      end
      S_HOLD: begin
        if (!id_stall && hold_valid) begin
          load         = 1'b1;
          hold_valid_d = 1'b0;
          state_d      = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (load) pc_d = load_next_pc;

    // A redirect overrides everything above; an in-flight response is marked for discard.
    if (ex_redirect) begin
      load         = 1'b0;
      pc_d         = {ex_target[31:2], 2'b00};
      hold_valid_d = 1'b0;
      unique case (state)
        S_REQ:  drop_d = imem_gnt;
        S_RESP: begin
          if (imem_rvalid) begin
            drop_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            drop_d  = 1'b1;
            state_d = S_RESP;
          end
        end
        S_HOLD: state_d = S_REQ;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= S_IDLE;
      pc               <= RESET_PC;
      drop             <= 1'b0;
      hold_valid       <= 1'b0;
      hold_inst        <= NOP_INST;
      imem_req         <= 1'b0;
      if_id_valid      <= 1'b0;
      if_id_pc         <= '0;
      if_id_inst       <= NOP_INST;
      if_id_pred_taken <= 1'b0;
    end else begin
      state      <= state_d;
      pc         <= pc_d;
      drop       <= drop_d;
      hold_valid <= hold_valid_d;
      hold_inst  <= hold_inst_d;
      imem_req   <= (state_d == S_REQ);
      if (ex_redirect) begin
        if_id_valid      <= 1'b0;
        if_id_inst       <= NOP_INST;
        if_id_pred_taken <= 1'b0;
      end else if (load) begin
        if_id_valid      <= 1'b1;
        if_id_pc         <= pc;
        if_id_inst       <= load_inst;
        if_id_pred_taken <= load_is_jal;
      end else if (!id_stall) begin
        if_id_valid      <= 1'b0;
        if_id_inst       <= NOP_INST;
        if_id_pred_taken <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed scenarios plus randomized traffic against an instruction-stream model.
// Build with IF_JAL_PRED_EN defined to exercise the JAL prediction variant.
module tb_if_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        id_stall;
  logic        ex_redirect;
  logic [31:0] ex_target;
  logic        if_id_valid;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_inst;
  logic        if_id_pred_taken;
  logic [1:0]  unused_dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  int n_deliv  = 0;

  // memory responder controls and state
  int          gnt_pct;
  int          rvd_lo, rvd_hi;
  logic        keep_on_reset;
  logic        pend, pend_stale;
  logic [31:0] pend_addr;
  int          wait_cnt;

  // expected instruction stream: head is {pred_taken, pc, inst} of the next instruction due in IF/ID
  logic [64:0] exp_q[$];

  if_fetch_stage #(.RESET_PC(RESET_PC), .NOP_INST(NOP_INST)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .id_stall(id_stall), .ex_redirect(ex_redirect), .ex_target(ex_target),
    .if_id_valid(if_id_valid), .if_id_pc(if_id_pc), .if_id_inst(if_id_inst),
    .if_id_pred_taken(if_id_pred_taken), .dbg_state(unused_dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    case (a)
      32'h0000_0000: w = 32'h0050_0093;
      32'h0000_0004: w = 32'h0020_8133;
      32'h0000_0040: w = 32'h0100_006F;
      default:       w = {a[26:2] ^ 25'h15A_5A5A, 7'b0010011};
    endcase
    return w;
  endfunction

  function automatic logic [64:0] entry_at(input logic [31:0] a);
    logic [31:0] w;
    logic        p;
    w = mem_word(a);
`ifdef IF_JAL_PRED_EN
    p = (w[6:0] == 7'h6F);
`else
    p = 1'b0;
`endif
    return {p, a, w};
  endfunction

  // successor in program order: JAL offset (when predicted) or the next word
  function automatic logic [31:0] succ_pc(input logic [64:0] e);
    int          off;
    logic [31:0] w;
    w = e[31:0];
    if (e[64]) begin
      off = int'(w[30:21]) * 2 + int'(w[20]) * 2048 + int'(w[19:12]) * 4096;
      if (w[31]) off = off - 1048576;
      return e[63:32] + 32'(off);
    end
    return e[63:32] + 32'd4;
  endfunction

  task automatic wait_valid(input string tag, input logic [31:0] exp_pc, input int max_cyc);
    int n;
    n = 0;
    while (!if_id_valid && n < max_cyc) begin
      tick();
      n++;
    end
    check_eq({tag, "_seen"}, 32'(if_id_valid), 32'd1);
    check_eq({tag, "_pc"}, if_id_pc, exp_pc);
  endtask

  // ---------------- memory responder ----------------
  initial begin : responder
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    pend = 1'b0; pend_stale = 1'b0; pend_addr = '0; wait_cnt = 0;
    forever begin
      @(negedge clk);
      imem_gnt    = 1'b0;
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
      if (rst && pend) begin
        if (keep_on_reset) pend_stale = 1'b1;
        else begin
          pend = 1'b0;
          pend_stale = 1'b0;
        end
      end
      if (pend) begin
        if (wait_cnt == 0) begin
          if (!rst) begin
            imem_rvalid = 1'b1;
            imem_rdata  = pend_stale ? 32'hDEAD_BEEF : mem_word(pend_addr);
            pend        = 1'b0;
            pend_stale  = 1'b0;
          end
        end else begin
          wait_cnt--;
        end
      end
      if (!rst && !pend && imem_req && ($urandom_range(0, 99) < gnt_pct)) begin
        imem_gnt  = 1'b1;
        pend      = 1'b1;
        pend_addr = imem_addr;
        wait_cnt  = $urandom_range(rvd_lo, rvd_hi);
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin : monitor
    logic        c_rst, c_stall, c_redir, c_gnt;
    logic [31:0] c_tgt;
    logic        p_valid, p_pred, p_req;
    logic [31:0] p_pc, p_inst, p_addr;
    logic [64:0] e;
    int          idle;
    p_valid = 1'b0; p_pred = 1'b0; p_req = 1'b0;
    p_pc = '0; p_inst = '0; p_addr = '0; idle = 0;
    forever begin
      @(posedge clk);
      c_rst = rst; c_stall = id_stall; c_redir = ex_redirect; c_gnt = imem_gnt; c_tgt = ex_target;
      #1;
      if (c_rst) begin
        exp_q.delete();
        exp_q.push_back(entry_at(RESET_PC));
        idle = 0;
        check_eq("rst_valid", 32'(if_id_valid), 32'd0);
        check_eq("rst_inst", if_id_inst, NOP_INST);
        check_eq("rst_pc", if_id_pc, 32'd0);
        check_eq("rst_pred", 32'(if_id_pred_taken), 32'd0);
        check_eq("rst_req", 32'(imem_req), 32'd0);
        check_eq("rst_addr", imem_addr, RESET_PC);
      end else begin
        if (c_redir) begin
          check_eq("redir_flush_valid", 32'(if_id_valid), 32'd0);
          check_eq("redir_flush_inst", if_id_inst, NOP_INST);
          check_eq("redir_flush_pred", 32'(if_id_pred_taken), 32'd0);
          exp_q.delete();
          exp_q.push_back(entry_at({c_tgt[31:2], 2'b00}));
          idle = 0;
        end else if (c_stall) begin
          check_eq("stall_hold_valid", 32'(if_id_valid), 32'(p_valid));
          check_eq("stall_hold_pc", if_id_pc, p_pc);
          check_eq("stall_hold_inst", if_id_inst, p_inst);
          check_eq("stall_hold_pred", 32'(if_id_pred_taken), 32'(p_pred));
        end else if (if_id_valid) begin
          e = exp_q.pop_front();
          check_eq("deliver_pc", if_id_pc, e[63:32]);
          check_eq("deliver_inst", if_id_inst, e[31:0]);
          check_eq("deliver_pred", 32'(if_id_pred_taken), 32'(e[64]));
          exp_q.push_back(entry_at(succ_pc(e)));
          n_deliv++;
          idle = 0;
        end else begin
          check_eq("bubble_inst", if_id_inst, NOP_INST);
          check_eq("bubble_pred", 32'(if_id_pred_taken), 32'd0);
        end
        if (p_req && !c_gnt && !c_redir) begin
          check_eq("req_held", 32'(imem_req), 32'd1);
          check_eq("req_addr_stable", imem_addr, p_addr);
        end
        if (imem_req && exp_q.size() != 0) check_eq("req_addr_next", imem_addr, exp_q[0][63:32]);
        idle++;
        if (idle > 400) begin
          check_eq("watchdog_progress", 32'd0, 32'd1);
          idle = 0;
        end
      end
      p_valid = if_id_valid; p_pc = if_id_pc; p_inst = if_id_inst;
      p_pred = if_id_pred_taken; p_req = imem_req; p_addr = imem_addr;
    end
  end

  // ---------------- stimulus ----------------
  initial begin : main
    logic [31:0] jal_next;
    int          n;
    rst = 1'b1; id_stall = 1'b0; ex_redirect = 1'b0; ex_target = '0;
    gnt_pct = 100; rvd_lo = 0; rvd_hi = 0; keep_on_reset = 1'b0;
    tick();
    tick();

    // basic fetch latency from reset
    rst = 1'b0;
    tick();
    check_eq("t1_e1_req", 32'(imem_req), 32'd1);
    check_eq("t1_e1_addr", imem_addr, 32'h0);
    tick();
    check_eq("t1_e2_req", 32'(imem_req), 32'd0);
    check_eq("t1_e2_valid", 32'(if_id_valid), 32'd0);
    tick();
    check_eq("t1_e3_valid", 32'(if_id_valid), 32'd1);
    check_eq("t1_e3_pc", if_id_pc, 32'h0);
    check_eq("t1_e3_inst", if_id_inst, 32'h0050_0093);
    check_eq("t1_e3_addr", imem_addr, 32'h4);

    // stall while the next response lands
    id_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("t2_hold_pc", if_id_pc, 32'h0);
      check_eq("t2_hold_inst", if_id_inst, 32'h0050_0093);
    end
    check_eq("t2_no_new_req", 32'(imem_req), 32'd0);
    id_stall = 1'b0;
    tick();
    check_eq("t2_rel_valid", 32'(if_id_valid), 32'd1);
    check_eq("t2_rel_pc", if_id_pc, 32'h4);
    check_eq("t2_rel_inst", if_id_inst, 32'h0020_8133);
    check_eq("t2_rel_addr", imem_addr, 32'h8);

    // redirect while a response is outstanding
    rvd_lo = 1; rvd_hi = 1;
    tick();
    ex_redirect = 1'b1; ex_target = 32'h100;
    tick();
    ex_redirect = 1'b0;
    check_eq("t3_flush", 32'(if_id_valid), 32'd0);
    tick();
    check_eq("t3_drop_valid", 32'(if_id_valid), 32'd0);
    check_eq("t3_new_req", 32'(imem_req), 32'd1);
    check_eq("t3_new_addr", imem_addr, 32'h100);
    rvd_lo = 0; rvd_hi = 0;
    wait_valid("t3_target", 32'h100, 20);

    // misaligned target with concurrent stall
    id_stall = 1'b1; ex_redirect = 1'b1; ex_target = 32'h0000_0203;
    tick();
    check_eq("t4_flush_valid", 32'(if_id_valid), 32'd0);
    check_eq("t4_flush_inst", if_id_inst, NOP_INST);
    id_stall = 1'b0; ex_redirect = 1'b0;
    tick();
    check_eq("t4_addr", imem_addr, 32'h200);
    wait_valid("t4_target", 32'h200, 20);

    // reset while a response is outstanding; its late rvalid must be ignored
    rvd_lo = 2; rvd_hi = 2; keep_on_reset = 1'b1;
    n = 0;
    while (!pend && n < 20) begin
      tick();
      n++;
    end
    check_eq("t5_granted", 32'(pend), 32'd1);
    rvd_lo = 0; rvd_hi = 0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    check_eq("t5_r1_inst", if_id_inst, NOP_INST);
    check_eq("t5_r1_addr", imem_addr, RESET_PC);
    tick();
    check_eq("t5_r2_valid", 32'(if_id_valid), 32'd0);
    check_eq("t5_r2_inst", if_id_inst, NOP_INST);
    tick();
    check_eq("t5_r3_valid", 32'(if_id_valid), 32'd1);
    check_eq("t5_r3_pc", if_id_pc, RESET_PC);
    check_eq("t5_r3_inst", if_id_inst, 32'h0050_0093);
    keep_on_reset = 1'b0;

    // JAL at 0x40
`ifdef IF_JAL_PRED_EN
    jal_next = 32'h50;
`else
    jal_next = 32'h44;
`endif
    ex_redirect = 1'b1; ex_target = 32'h40;
    tick();
    ex_redirect = 1'b0;
    wait_valid("t6_jal", 32'h40, 20);
`ifdef IF_JAL_PRED_EN
    check_eq("t6_pred", 32'(if_id_pred_taken), 32'd1);
`else
    check_eq("t6_pred", 32'(if_id_pred_taken), 32'd0);
`endif
    check_eq("t6_next_addr", imem_addr, jal_next);
    tick();
    wait_valid("t6_next", jal_next, 20);

    // PC wrap at the top of the address space
    ex_redirect = 1'b1; ex_target = 32'hFFFF_FFFE;
    tick();
    ex_redirect = 1'b0;
    wait_valid("t7_top", 32'hFFFF_FFFC, 20);
    tick();
    wait_valid("t7_wrap", 32'h0, 20);
    check_eq("t7_wrap_inst", if_id_inst, 32'h0050_0093);

    // randomized traffic
    rvd_lo = 0; rvd_hi = 3;
    for (int i = 0; i < 4000; i++) begin
      if (i % 500 == 0) gnt_pct = $urandom_range(30, 100);
      id_stall    = ($urandom_range(0, 99) < 25);
      ex_redirect = ($urandom_range(0, 99) < 3);
      rst         = ($urandom_range(0, 999) < 3);
      case ($urandom_range(0, 3))
        0, 1:    ex_target = $urandom;
        2:       ex_target = $urandom_range(0, 127);
        default: ex_target = 32'hFFFF_FFF0 | $urandom_range(0, 15);
      endcase
      tick();
    end
    rst = 1'b0; id_stall = 1'b0; ex_redirect = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    check_eq("enough_deliveries", 32'(n_deliv > 300), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
